// File: rtl/lmk01801_uwire_master_if.sv
// Command/status bundle between software-side logic and the LMK01801 uWire master.
// The master modport belongs to the command source; the slave modport belongs to the uWire master.
interface lmk01801_uwire_master_if;
    logic [31:0] cmd_data;
    logic        cmd_read;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        busy;
    logic        done;
    logic [31:0] rd_data;
    logic        rd_valid;

    modport master (
        output cmd_data, cmd_read, cmd_valid,
        input  cmd_ready, busy, done, rd_data, rd_valid
    );

    modport slave (
        input  cmd_data, cmd_read, cmd_valid,
        output cmd_ready, busy, done, rd_data, rd_valid
    );
endinterface

// File: rtl/lmk01801_uwire_master.sv
// MICROWIRE programming master for the LMK01801 clock distributor.
// Shifts 32-bit words MSB-first, pulses LE to latch them, then idles for a gap.
// Optional readback (define LMK01801_UWIRE_READBACK_EN) clocks a 32-bit word
// back in after the LE pulse when the command requests it.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a command; cmd_ready high
// SHIFT | clocking the 32-bit word out on uwire_data_o
// LATCH | uwire_le held high for LE_CYCLES
// READ  | (readback build) clocking 32 bits in, data pin released
// GAP   | quiet time after LE; done pulses on the final cycle
module lmk01801_uwire_master #(
    parameter int DIV        = 4,
    parameter int LE_CYCLES  = 8,
    parameter int GAP_CYCLES = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    lmk01801_uwire_master_if.slave       cmd,
    output logic                         uwire_clk,
    output logic                         uwire_le,
    output logic                         uwire_data_o,
    output logic                         uwire_data_oe,
    input  logic                         uwire_data_i
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SHIFT = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
`ifdef LMK01801_UWIRE_READBACK_EN
    localparam logic [2:0] S_READ  = 3'd4;
`endif

    localparam logic [7:0] DIV_M1 = 8'(DIV - 1);
    localparam logic [7:0] LE_M1  = 8'(LE_CYCLES - 1);
    localparam logic [7:0] GAP_M1 = 8'(GAP_CYCLES - 1);

    logic [2:0]  state;
    logic [7:0]  phase_cnt;
    logic [5:0]  bit_cnt;
    logic [31:0] sreg;
    logic        uclk_q;
    logic        phase_tc;
    logic        bit_last;

    assign phase_tc = (phase_cnt == 8'd0);
    assign bit_last = (bit_cnt == 6'd31);

`ifdef LMK01801_UWIRE_READBACK_EN
    logic        rd_flag;
    logic        din_q;
    logic [31:0] cap_q;
    logic [31:0] rd_data_q;
    logic        rd_valid_q;
`endif

    // Sequencer: one down-counter times every phase (bit half-periods, LE width, gap).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            phase_cnt <= '0;
            bit_cnt   <= '0;
            sreg      <= '0;
            uclk_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd.cmd_valid) begin
                        sreg      <= cmd.cmd_data;
                        bit_cnt   <= '0;
                        phase_cnt <= DIV_M1;
                        uclk_q    <= 1'b0;
                        state     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (phase_tc) begin
                        phase_cnt <= DIV_M1;
                        if (!uclk_q) begin
                            uclk_q <= 1'b1;
                        end else begin
                            // data moves only on the falling edge of uwire_clk
                            uclk_q <= 1'b0;
                            sreg   <= {sreg[30:0], 1'b0};
                            if (bit_last) begin
                                state     <= S_LATCH;
                                phase_cnt <= LE_M1;
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
                S_LATCH: begin
                    if (phase_tc) begin
`ifdef LMK01801_UWIRE_READBACK_EN
                        if (rd_flag) begin
                            state     <= S_READ;
                            phase_cnt <= DIV_M1;
                            bit_cnt   <= '0;
                        end else begin
                            state     <= S_GAP;
                            phase_cnt <= GAP_M1;
                        end
`else
                        state     <= S_GAP;
                        phase_cnt <= GAP_M1;
`endif
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
`ifdef LMK01801_UWIRE_READBACK_EN
                S_READ: begin
                    if (phase_tc) begin
                        phase_cnt <= DIV_M1;
                        if (!uclk_q) begin
                            uclk_q <= 1'b1;
                        end else begin
                            uclk_q <= 1'b0;
                            if (bit_last) begin
                                state     <= S_GAP;
                                phase_cnt <= GAP_M1;
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
`endif
                S_GAP: begin
                    if (phase_tc) begin
                        state <= S_IDLE;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef LMK01801_UWIRE_READBACK_EN
    // Readback capture: sample the registered pin on the last low-phase cycle of each bit.
    // rd_data/rd_valid update on the final sample, inside READ, so rd_valid can never meet done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_flag    <= 1'b0;
            din_q      <= 1'b0;
            cap_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            din_q      <= uwire_data_i;
            rd_valid_q <= 1'b0;
            if (state == S_IDLE && cmd.cmd_valid) begin
                rd_flag <= cmd.cmd_read;
            end
            if (state == S_READ && phase_tc && !uclk_q) begin
                cap_q <= {cap_q[30:0], din_q};
                if (bit_last) begin
                    rd_data_q  <= {cap_q[30:0], din_q};
                    rd_valid_q <= 1'b1;
                end
            end
        end
    end

    assign uwire_data_oe = (state != S_READ);
    assign cmd.rd_data   = rd_data_q;
    assign cmd.rd_valid  = rd_valid_q;
`else
    logic unused_inputs;
    assign unused_inputs = cmd.cmd_read ^ uwire_data_i;

    assign uwire_data_oe = 1'b1;
    assign cmd.rd_data   = 32'd0;
    assign cmd.rd_valid  = 1'b0;
`endif

    assign cmd.cmd_ready = (state == S_IDLE);
    assign cmd.busy      = (state != S_IDLE);
    assign cmd.done      = (state == S_GAP) && phase_tc;
    assign uwire_clk     = uclk_q;
    assign uwire_le      = (state == S_LATCH);
    assign uwire_data_o  = (state == S_SHIFT) && sreg[31];

endmodule
